// File: rtl/prio_arb_pkg.sv
// Shared types and constants for the 8-requester priority arbiter.
package prio_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        onehot8 = '0;
        onehot8[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/prio_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface prio_arbiter8_if;
    import prio_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             preempt;

    modport master (output req, input gnt, input gnt_idx, input gnt_vld, input preempt);
    modport slave  (input req, output gnt, output gnt_idx, output gnt_vld, output preempt);

endinterface

// File: rtl/prio_enc8.sv
// Combinational 8:3 priority encoder; the highest set bit wins.
module prio_enc8
    import prio_arb_pkg::*;
(
    input  logic [N_REQ-1:0] in,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    always_comb begin
        idx = '0;
        vld = |in;
        // Ascending scan so the last (highest) set bit overwrites lower ones.
        for (int i = 0; i < N_REQ; i++) begin
            if (in[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/prio_arbiter8.sv
// 8-requester arbiter with hold timeout and preemption.
// Define PRIO_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed (bit 7 highest).
module prio_arbiter8
    import prio_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    prio_arbiter8_if.slave bus
);

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HoldMax  = '1;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             vld_q, vld_d;
    logic             pre_q, pre_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic             owner_req;
    logic             timeout;
    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] rot_amt;
    logic [2*N_REQ-1:0] rot_wide;
    logic [N_REQ-1:0] enc_in;
    logic [IDX_W-1:0] enc_idx;
    logic             win_vld;
    logic [IDX_W-1:0] win_idx;

    always_comb begin
        owner_req = bus.req[idx_q];
        timeout   = (MAX_HOLD != 0) && (state_q == BUSY) && owner_req && (hold_cnt_q == HoldLast);
        cand      = timeout ? (bus.req & ~gnt_q) : bus.req;
        // Rotating right by last_idx puts bit (last_idx-1) at bit 7, the encoder's top priority.
        rot_amt   = last_q & {IDX_W{RrEn}};
        rot_wide  = {cand, cand} >> rot_amt;
        enc_in    = rot_wide[N_REQ-1:0];
        win_idx   = enc_idx + rot_amt;
    end

    prio_enc8 u_enc (
        .in  (enc_in),
        .idx (enc_idx),
        .vld (win_vld)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        vld_d      = vld_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        pre_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (win_vld) begin
                    state_d = BUSY;
                    gnt_d   = onehot8(win_idx);
                    idx_d   = win_idx;
                    vld_d   = 1'b1;
                    last_d  = win_idx;
                end
            end
            BUSY: begin
                if (!owner_req) begin
                    hold_cnt_d = '0;
                    if (win_vld) begin
                        gnt_d  = onehot8(win_idx);
                        idx_d  = win_idx;
                        last_d = win_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        vld_d   = 1'b0;
                    end
                end else if (timeout && win_vld) begin
                    gnt_d      = onehot8(win_idx);
                    idx_d      = win_idx;
                    last_d     = win_idx;
                    pre_d      = 1'b1;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != HoldMax) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            idx_q      <= '0;
            vld_q      <= 1'b0;
            pre_q      <= 1'b0;
            last_q     <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            idx_q      <= idx_d;
            vld_q      <= vld_d;
            pre_q      <= pre_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = vld_q;
    assign bus.preempt = pre_q;

endmodule

// File: tb/tb_prio_arbiter8.sv
// Directed self-checking bench for prio_arbiter8 (MAX_HOLD=4).
module tb_prio_arbiter8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    prio_arbiter8_if bus ();

    prio_arbiter8 #(
        .MAX_HOLD (4),
        .HOLD_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (bus.gnt !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_gnt: got %h expected 00", bus.gnt);
            end
            vectors++;
            if (bus.gnt_vld !== 1'b0 || bus.preempt !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_vld_pre: got vld=%b pre=%b expected 0 0",
                         bus.gnt_vld, bus.preempt);
            end
        end
        rst = 1'b0;
        bus.req = 8'h00;
        tick();
        vectors++;
        if (bus.gnt_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got vld=%b expected 0", bus.gnt_vld);
        end
    endtask

    task automatic test_walk();
        logic [7:0] exp_gnt;
        for (int i = 7; i >= 0; i--) begin
            exp_gnt = 8'h01 << i;
            bus.req = exp_gnt;
            vectors++;
            if (bus.gnt_vld !== 1'b0) begin
                miscompares++;
                $display("FAIL walk_latency[%0d]: got vld=%b expected 0", i, bus.gnt_vld);
            end
            for (int c = 0; c < 3; c++) begin
                tick();
                vectors++;
                if (bus.gnt !== exp_gnt || bus.gnt_idx !== 3'(i) || bus.gnt_vld !== 1'b1) begin
                    miscompares++;
                    $display("FAIL walk[%0d]: got gnt=%h idx=%0d vld=%b expected gnt=%h idx=%0d vld=1",
                             i, bus.gnt, bus.gnt_idx, bus.gnt_vld, exp_gnt, i);
                end
            end
            bus.req = 8'h00;
            tick();
            vectors++;
            if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0) begin
                miscompares++;
                $display("FAIL walk_idle[%0d]: got gnt=%h vld=%b expected 00 0",
                         i, bus.gnt, bus.gnt_vld);
            end
        end
    endtask

    task automatic test_handoff();
        bus.req = 8'b1000_1000;
        tick();
        vectors++;
        if (bus.gnt_idx !== 3'd7 || bus.gnt !== 8'h80) begin
            miscompares++;
            $display("FAIL handoff_first: got idx=%0d gnt=%h expected 7 80", bus.gnt_idx, bus.gnt);
        end
        bus.req = 8'b0000_1000;
        tick();
        vectors++;
        if (bus.gnt_idx !== 3'd3 || bus.gnt !== 8'h08 || bus.gnt_vld !== 1'b1) begin
            miscompares++;
            $display("FAIL handoff_next: got idx=%0d gnt=%h vld=%b expected 3 08 1",
                     bus.gnt_idx, bus.gnt, bus.gnt_vld);
        end
        bus.req = 8'h00;
        tick();
        vectors++;
        if (bus.gnt_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL handoff_idle: got vld=%b expected 0", bus.gnt_vld);
        end
    endtask

    task automatic test_timeout();
        // Per cycle after each edge: expected owner and preempt pulse.
        logic [2:0] exp_idx [9] = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7};
        logic       exp_pre [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.req = 8'h81;
        for (int c = 0; c < 9; c++) begin
            tick();
            vectors++;
            if (bus.gnt_idx !== exp_idx[c] || bus.preempt !== exp_pre[c] ||
                bus.gnt !== (8'h01 << exp_idx[c])) begin
                miscompares++;
                $display("FAIL timeout[%0d]: got idx=%0d pre=%b gnt=%h expected idx=%0d pre=%b",
                         c, bus.gnt_idx, bus.preempt, bus.gnt, exp_idx[c], exp_pre[c]);
            end
        end
        bus.req = 8'h00;
        tick();
        vectors++;
        if (bus.gnt_vld !== 1'b0 || bus.preempt !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_idle: got vld=%b pre=%b expected 0 0", bus.gnt_vld, bus.preempt);
        end
    endtask

    task automatic test_saturate();
        int bad = 0;
        bus.req = 8'h10;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (bus.gnt !== 8'h10 || bus.gnt_idx !== 3'd4 || bus.preempt !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL saturate_hold: got %0d bad cycles expected 0", bad);
        end
        vectors++;
        if (dut.hold_cnt_q !== 8'd255) begin
            miscompares++;
            $display("FAIL saturate_cnt: got %0d expected 255", dut.hold_cnt_q);
        end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [8] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        logic [2:0] prev;
        bus.req = 8'hFF;
        tick();
        vectors++;
        if (bus.gnt_idx !== 3'd7 || bus.gnt_vld !== 1'b1) begin
            miscompares++;
            $display("FAIL rr_first: got idx=%0d vld=%b expected 7 1", bus.gnt_idx, bus.gnt_vld);
        end
        prev = 3'd7;
        for (int k = 0; k < 8; k++) begin
            bus.req = ~(8'h01 << prev);
            tick();
            vectors++;
            if (bus.gnt_idx !== exp_seq[k] || bus.gnt !== (8'h01 << exp_seq[k])) begin
                miscompares++;
                $display("FAIL rr_seq[%0d]: got idx=%0d gnt=%h expected idx=%0d",
                         k, bus.gnt_idx, bus.gnt, exp_seq[k]);
            end
            prev = exp_seq[k];
        end
        bus.req = 8'hFF;
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_reset: got gnt=%h vld=%b expected 00 0", bus.gnt, bus.gnt_vld);
        end
        rst = 1'b0;
        bus.req = 8'h00;
        tick();
    endtask

    initial begin
        bus.req = 8'h00;
        test_reset();
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        test_round_robin();
`else
        test_walk();
        test_handoff();
`endif
        test_timeout();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
